// File: rtl/sim_pcie_rx_tlp_gen_if.sv
// Command and AXI-Stream RX bundle for the simulation TLP injector.
// The master modport is the generator side; slave is the stimulus/consumer side.
interface sim_pcie_rx_tlp_gen_if;
    localparam int unsigned DW_W   = 32;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned USER_W = 22;
    localparam int unsigned CNT_W  = 16;

    logic              i_cmd_stb;
    logic              i_cmd_rd;
    logic [DW_W-1:0]   i_cmd_addr;
    logic [LEN_W-1:0]  i_cmd_len;
    logic [TAG_W-1:0]  i_cmd_tag;
    logic [DW_W-1:0]   i_cmd_seed;
    logic              o_cmd_rdy;
    logic              o_cmd_err;

    logic [DW_W-1:0]   m_axis_rx_tdata;
    logic [3:0]        m_axis_rx_tkeep;
    logic              m_axis_rx_tlast;
    logic              m_axis_rx_tvalid;
    logic              m_axis_rx_tready;
    logic [USER_W-1:0] m_axis_rx_tuser;
    logic              rx_np_ok;

    logic [CNT_W-1:0]  o_wr_count;
    logic [CNT_W-1:0]  o_rd_count;

    modport master (
        input  i_cmd_stb, i_cmd_rd, i_cmd_addr, i_cmd_len, i_cmd_tag, i_cmd_seed,
        input  m_axis_rx_tready, rx_np_ok,
        output o_cmd_rdy, o_cmd_err,
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid, m_axis_rx_tuser,
        output o_wr_count, o_rd_count
    );

    modport slave (
        output i_cmd_stb, i_cmd_rd, i_cmd_addr, i_cmd_len, i_cmd_tag, i_cmd_seed,
        output m_axis_rx_tready, rx_np_ok,
        input  o_cmd_rdy, o_cmd_err,
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid, m_axis_rx_tuser,
        input  o_wr_count, o_rd_count
    );
endinterface

// File: rtl/sim_pcie_rx_tlp_gen.sv
// Simulation host-side TLP injector: single-cycle commands become 3DW MWr/MRd TLPs on 32-bit AXI-Stream RX.
// Define SIM_RX_TLP_STATS_EN to build the completed-MWr/MRd counters; otherwise both counts are tied to 0.
module sim_pcie_rx_tlp_gen #(
    parameter logic [15:0] REQUESTER_ID = 16'h0100,
    parameter logic [6:0]  BAR_HIT      = 7'h01,
    parameter logic [10:0] MAX_PAYLOAD  = 11'd128
) (
    input  logic                  sys_clk_p,
    input  logic                  sys_reset,
    sim_pcie_rx_tlp_gen_if.master bus
);
    localparam int unsigned DW_W  = 32;
    localparam int unsigned LEN_W = 10;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned TAG_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NP_WAIT = 3'd1,
        S_HDR0    = 3'd2,
        S_HDR1    = 3'd3,
        S_HDR2    = 3'd4,
        S_DATA    = 3'd5
    } state_e;

    state_e             state_q,   state_d;
    logic               tvalid_q,  tvalid_d;
    logic               tlast_q,   tlast_d;
    logic [DW_W-1:0]    tdata_q,   tdata_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               cmd_err_q, cmd_err_d;
    logic               rd_q,      rd_d;
    logic [DW_W-1:0]    addr_q,    addr_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [TAG_W-1:0]   tag_q,     tag_d;
    logic [DW_W-1:0]    seed_q,    seed_d;
    logic [CNT_W-1:0]   rem_q,     rem_d;

    logic beat_c;
    logic done_c;

    // A length field of 0 means 1024 DW.
    function automatic logic [CNT_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? 11'd1024 : {1'b0, len};
    endfunction

    function automatic logic [DW_W-1:0] mk_hdr0(input logic rd, input logic [LEN_W-1:0] len);
        return {1'b0, (rd ? 2'b00 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'h0,
                1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction

    function automatic logic [DW_W-1:0] mk_hdr1(input logic [TAG_W-1:0] tag, input logic [LEN_W-1:0] len);
        return {REQUESTER_ID, tag, ((len == 10'd1) ? 4'h0 : 4'hF), 4'hF};
    endfunction

    assign beat_c = tvalid_q && bus.m_axis_rx_tready;
    assign done_c = beat_c && tlast_q;

    always_comb begin
        state_d   = state_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        cmd_rdy_d = cmd_rdy_q;
        cmd_err_d = 1'b0;
        rd_d      = rd_q;
        addr_d    = addr_q;
        len_d     = len_q;
        tag_d     = tag_q;
        seed_d    = seed_q;
        rem_d     = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_stb) begin
                    if (!bus.i_cmd_rd && (eff_len(bus.i_cmd_len) > MAX_PAYLOAD)) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        rd_d      = bus.i_cmd_rd;
                        addr_d    = bus.i_cmd_addr & 32'hFFFF_FFFC;
                        len_d     = bus.i_cmd_len;
                        tag_d     = bus.i_cmd_tag;
                        seed_d    = bus.i_cmd_seed;
                        cmd_rdy_d = 1'b0;
                        if (bus.i_cmd_rd) begin
                            state_d = S_NP_WAIT;
                        end else begin
                            state_d  = S_HDR0;
                            tvalid_d = 1'b1;
                            tlast_d  = 1'b0;
                            tdata_d  = mk_hdr0(1'b0, bus.i_cmd_len);
                        end
                    end
                end
            end
            S_NP_WAIT: begin
                if (bus.rx_np_ok) begin
                    state_d  = S_HDR0;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = mk_hdr0(1'b1, len_q);
                end
            end
            S_HDR0: begin
                if (beat_c) begin
                    state_d = S_HDR1;
                    tdata_d = mk_hdr1(tag_q, len_q);
                end
            end
            S_HDR1: begin
                if (beat_c) begin
                    state_d = S_HDR2;
                    tdata_d = addr_q;
                    tlast_d = rd_q;
                end
            end
            S_HDR2: begin
                if (beat_c && !rd_q) begin
                    state_d = S_DATA;
                    tdata_d = seed_q;
                    rem_d   = eff_len(len_q) - 11'd1;
                    tlast_d = (eff_len(len_q) == 11'd1);
                end
            end
            S_DATA: begin
                // rem_q counts DWs still to follow the one on the bus
                if (beat_c && !tlast_q) begin
                    tdata_d = tdata_q + 32'd1;
                    rem_d   = rem_q - 11'd1;
                    tlast_d = (rem_q == 11'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_c) begin
            state_d   = S_IDLE;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            cmd_rdy_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            state_q   <= S_IDLE;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            cmd_rdy_q <= 1'b1;
            cmd_err_q <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            tag_q     <= '0;
            seed_q    <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            cmd_rdy_q <= cmd_rdy_d;
            cmd_err_q <= cmd_err_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            tag_q     <= tag_d;
            seed_q    <= seed_d;
            rem_q     <= rem_d;
        end
    end

    assign bus.m_axis_rx_tdata  = tdata_q;
    assign bus.m_axis_rx_tvalid = tvalid_q;
    assign bus.m_axis_rx_tlast  = tlast_q;
    assign bus.m_axis_rx_tkeep  = 4'hF;
    assign bus.m_axis_rx_tuser  = {13'h0, BAR_HIT, 2'b00};
    assign bus.o_cmd_rdy        = cmd_rdy_q;
    assign bus.o_cmd_err        = cmd_err_q;

`ifdef SIM_RX_TLP_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;

    // Counts TLPs whose tlast beat transferred; wraps naturally at 16 bits.
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (done_c) begin
            if (rd_q) rd_count_d = rd_count_q + 16'd1;
            else      wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk_p or posedge sys_reset) begin
        if (sys_reset) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign bus.o_wr_count = wr_count_q;
    assign bus.o_rd_count = rd_count_q;
`else
    assign bus.o_wr_count = 16'h0;
    assign bus.o_rd_count = 16'h0;
`endif
endmodule
